// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the single-port RAM controller.
//   - default RAM geometry (address width, data width, number of valid words)
//   - command op-codes presented on cmd_op
//   - controller state encoding
package ram_pkg;

   localparam int RAM_ADDR_W = 5;
   localparam int RAM_DATA_W = 3;
   localparam int RAM_DEPTH  = 5;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_ADDR = 3'd2,
      RD_CAP  = 3'd3,
      CLR     = 3'd4
   } state_t;

endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator-side controller for a single-port synchronous RAM
// (registered read address, write when rw=1).
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 read, 01 write, 10 clear-fill, 11 reserved
//   cmd_addr, cmd_wdata   target address / write data or fill value
//   rsp_valid             one-cycle response pulse, one per accepted command
//   rsp_rdata, rsp_err    read data (0 otherwise) and error flag
//   ram_rw, ram_addr,
//   ram_data, ram_q       RAM macro pins
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high exactly while the FSM is IDLE,
// including the cycle in which a response pulses, so commands can be issued
// back to back. Responses have no backpressure.
//
// The FSM state is kept in the signal 'state' so checkers can bind to it.
module ram_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter int DEPTH  = RAM_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);

   // Comparing against the last valid address (rather than DEPTH) keeps the
   // check correct even when DEPTH equals 2**ADDR_W.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] fill_cnt;
   logic [ADDR_W-1:0] fill_cnt_nxt;
   logic              ram_rw_nxt;
   logic [ADDR_W-1:0] ram_addr_nxt;
   logic [DATA_W-1:0] ram_data_nxt;
   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic              rsp_err_nxt;
   logic              addr_ok;

   assign cmd_ready = (state == IDLE);
   assign addr_ok   = (cmd_addr <= LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fill_cnt  <= '0;
         ram_rw    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         fill_cnt  <= fill_cnt_nxt;
         ram_rw    <= ram_rw_nxt;
         ram_addr  <= ram_addr_nxt;
         ram_data  <= ram_data_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
      end
   end

   // Next-state and next-output logic. Address/data pins hold their last
   // value unless a new access is launched; rw and the response default low.
   always_comb begin
      state_nxt     = state;
      fill_cnt_nxt  = fill_cnt;
      ram_rw_nxt    = 1'b0;
      ram_addr_nxt  = ram_addr;
      ram_data_nxt  = ram_data;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = '0;
      rsp_err_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               unique case (cmd_op)
                  OP_RD: begin
                     if (addr_ok) begin
                        state_nxt    = RD_ADDR;
                        ram_addr_nxt = cmd_addr;
                     end else begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                     end
                  end
                  OP_WR: begin
                     if (addr_ok) begin
                        state_nxt    = WR;
                        ram_rw_nxt   = 1'b1;
                        ram_addr_nxt = cmd_addr;
                        ram_data_nxt = cmd_wdata;
                     end else begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                     end
                  end
                  OP_CLR: begin
                     // The fill value is captured once into ram_data and held
                     // for the whole sweep.
                     state_nxt    = CLR;
                     fill_cnt_nxt = '0;
                     ram_rw_nxt   = 1'b1;
                     ram_addr_nxt = '0;
                     ram_data_nxt = cmd_wdata;
                  end
                  default: begin
                     rsp_valid_nxt = 1'b1;
                     rsp_err_nxt   = 1'b1;
                  end
               endcase
            end
         end

         WR: begin
            state_nxt     = IDLE;
            rsp_valid_nxt = 1'b1;
         end

         // The RAM latches ram_addr at the end of this cycle; q follows in
         // the next one.
         RD_ADDR: begin
            state_nxt = RD_CAP;
         end

         RD_CAP: begin
            state_nxt     = IDLE;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = ram_q;
         end

         // fill_cnt mirrors the address being written this cycle.
         CLR: begin
            if (fill_cnt == LAST_ADDR) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b1;
            end else begin
               fill_cnt_nxt = fill_cnt + ADDR_W'(1);
               ram_rw_nxt   = 1'b1;
               ram_addr_nxt = fill_cnt + ADDR_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed self-checking bench for ram_ctrl, with a behavioural
// model of the single-port RAM (registered read address) attached to it.
module tb_ram_ctrl;
   import ram_pkg::*;

   localparam int ADDR_W = RAM_ADDR_W;
   localparam int DATA_W = RAM_DATA_W;
   localparam int DEPTH  = RAM_DEPTH;

   logic              clk;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              ram_rw;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_q;

   int n_checks = 0;
   int n_errors = 0;

   // scoreboard: expected {rsp_err, rsp_rdata} per response, in order
   logic [DATA_W:0] exp_q[$];

   ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_rw    (ram_rw),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_q     (ram_q)
   );

   // ---------------- RAM model ----------------
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] ram_addr_q;

   always @(posedge clk) begin
      if (ram_rw) mem[ram_addr] <= ram_data;
      ram_addr_q <= ram_addr;
   end
   assign ram_q = mem[ram_addr_q];

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // response monitor: every pulse must match the head of the expected queue
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_spurious", 32'(rsp_valid), 32'd0);
         end else begin
            check("rsp_data", 32'({rsp_err, rsp_rdata}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- drivers ----------------
   // Called right after a negedge with the controller idle. After the
   // accepting edge the command inputs are scrambled to show they are captured.
   task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata);
      check("cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_addr  = ADDR_W'($urandom_range(0, (1<<ADDR_W)-1));
      cmd_wdata = DATA_W'($urandom_range(0, (1<<DATA_W)-1));
   endtask

   // Issues one command and checks, cycle by cycle, the RAM pins and that
   // rsp_valid pulses exactly at the given latency. Ends on the negedge of
   // the response cycle, so a following call is back to back.
   task automatic do_cmd(input string tag, input logic [1:0] op,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic err, input logic [DATA_W-1:0] rdata, input int lat);
      logic rw_exp;
      exp_q.push_back({err, rdata});
      issue(op, addr, wdata);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(k == lat));
         rw_exp = !err && ((op == OP_WR && k == 1) || (op == OP_CLR && k <= DEPTH));
         check({tag, "_ram_rw"}, 32'(ram_rw), 32'(rw_exp));
         if (rw_exp) begin
            check({tag, "_ram_addr"}, 32'(ram_addr), (op == OP_CLR) ? 32'(k - 1) : 32'(addr));
            check({tag, "_ram_data"}, 32'(ram_data), 32'(wdata));
         end
         if (op == OP_RD && !err && k == 1)
            check({tag, "_rd_addr"}, 32'(ram_addr), 32'(addr));
      end
      check({tag, "_ready_in_rsp"}, 32'(cmd_ready), 32'd1);
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_RD;
      cmd_addr  = '0;
      cmd_wdata = '0;

      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_ram_rw",    32'(ram_rw),    32'd0);
      check("rst_ram_addr",  32'(ram_addr),  32'd0);
      check("rst_ram_data",  32'(ram_data),  32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // write then read back: latency 2 and 3
      do_cmd("wr2", OP_WR, 5'd2, 3'b101, 1'b0, 3'b000, 2);
      do_cmd("rd2", OP_RD, 5'd2, 3'b000, 1'b0, 3'b101, 3);

      // clear-fill: five write cycles at 0..4, response one cycle later
      do_cmd("clr", OP_CLR, 5'd17, 3'b111, 1'b0, 3'b000, DEPTH + 1);
      for (int a = 0; a < DEPTH; a++)
         do_cmd("rd_clr", OP_RD, ADDR_W'(a), 3'b000, 1'b0, 3'b111, 3);

      // errors: first out-of-range address, reserved op; no RAM access
      do_cmd("rd_oob",  OP_RD,  5'd5,  3'b000, 1'b1, 3'b000, 1);
      do_cmd("rsv",     OP_RSV, 5'd1,  3'b010, 1'b1, 3'b000, 1);
      do_cmd("wr_oob",  OP_WR,  5'd5,  3'b001, 1'b1, 3'b000, 1);
      do_cmd("wr_oob2", OP_WR,  5'd31, 3'b001, 1'b1, 3'b000, 1);
      for (int a = 0; a < DEPTH; a++)
         do_cmd("rd_after_err", OP_RD, ADDR_W'(a), 3'b000, 1'b0, 3'b111, 3);

      // back to back: read issued in the write's response cycle
      do_cmd("wr4", OP_WR, 5'd4, 3'b011, 1'b0, 3'b000, 2);
      do_cmd("rd4", OP_RD, 5'd4, 3'b000, 1'b0, 3'b011, 3);
      do_cmd("wr3", OP_WR, 5'd3, 3'b010, 1'b0, 3'b000, 2);

      // reset mid-clear, once addresses 0..2 have been written
      issue(OP_CLR, 5'd0, 3'b001);
      repeat (4) @(negedge clk);
      check("mid_clr_rw",   32'(ram_rw),   32'd1);
      check("mid_clr_addr", 32'(ram_addr), 32'd3);
      rst_n = 1'b0;
      #1;
      check("async_rst_rw",    32'(ram_rw),    32'd0);
      check("async_rst_ready", 32'(cmd_ready), 32'd1);
      repeat (2) begin
         @(negedge clk);
         check("rst_no_rsp", 32'(rsp_valid), 32'd0);
         check("rst_no_rw",  32'(ram_rw),    32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_rsp",   32'(rsp_valid), 32'd0);
      for (int a = 0; a < 3; a++)
         do_cmd("rd_partial", OP_RD, ADDR_W'(a), 3'b000, 1'b0, 3'b001, 3);
      do_cmd("rd_kept3", OP_RD, 5'd3, 3'b000, 1'b0, 3'b010, 3);
      do_cmd("rd_kept4", OP_RD, 5'd4, 3'b000, 1'b0, 3'b011, 3);

      repeat (2) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
